// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT input framer.
//   DATA  - sample component width (signed, two's complement)
//   ARRAY - lanes per output vector (power of 2)
//   N     - FFT frame length in samples (power of 2, multiple of ARRAY)
//   VECS  - vectors per frame, derived as N/ARRAY
package fft_pkg;

  localparam int DATA      = 10;
  localparam int ARRAY     = 16;
  localparam int N         = 512;
  localparam int VECS      = N / ARRAY;

  localparam int LOG_ARRAY = $clog2(ARRAY);
  localparam int LOG_N     = $clog2(N);
  localparam int LOG_VECS  = $clog2(VECS);

  typedef struct packed {
    logic signed [DATA-1:0] re;
    logic signed [DATA-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: ping-pong frame storage, 2 banks x VECS vectors x ARRAY lanes.
// Ports:
//   clk      - clock
//   we       - write one lane this cycle
//   wr_bank  - bank to write
//   wr_vec   - vector index within the bank
//   wr_lane  - lane index within the vector
//   wr_data  - complex sample to store
//   rd_bank  - bank to read
//   rd_vec   - vector index within the bank
//   rd_data  - full ARRAY-lane vector, combinational read
// Storage has no reset: contents are only consumed after a full frame has
// been written, so stale data is never observed.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic                 wr_bank,
  input  logic [LOG_VECS-1:0]  wr_vec,
  input  logic [LOG_ARRAY-1:0] wr_lane,
  input  cplx_t                wr_data,
  input  logic                 rd_bank,
  input  logic [LOG_VECS-1:0]  rd_vec,
  output cplx_t [ARRAY-1:0]    rd_data
);

  cplx_t [ARRAY-1:0] mem [2][VECS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_vec][wr_lane] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_vec];

endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: packs a serial complex sample stream into ARRAY-lane
// vectors in a ping-pong buffer and streams each completed frame as VECS
// back-to-back vectors with one contiguous valid_out burst (the form the
// first FFT stage's delay lines expect).
// Ports:
//   clk, rstn    - clock, asynchronous active-low reset
//   s_valid      - input sample valid
//   s_ready      - framer can accept a sample
//   s_re, s_im   - sample real / imaginary parts
//   s_last       - final sample of a frame
//   err_clr      - synchronous clear of frame_err
//   valid_out    - output vector valid (drives stage valid_in)
//   dout_re/im   - output vector, lane l in [l]
//   frame_start  - high with the first vector of each frame
//   frame_err    - sticky framing error flag
//
// Handshake: a sample is transferred on a rising clk edge where s_valid and
// s_ready are both high. s_ready depends only on registered state (never on
// s_valid); the source must hold s_valid and its data stable until transfer.
// The output side has no backpressure: valid_out qualifies each vector for
// exactly one cycle.
module fft_input_framer
  import fft_pkg::*;
(
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic signed [DATA-1:0]             s_re,
  input  logic signed [DATA-1:0]             s_im,
  input  logic                               s_last,
  input  logic                               err_clr,
  output logic                               valid_out,
  output logic signed [ARRAY-1:0][DATA-1:0]  dout_re,
  output logic signed [ARRAY-1:0][DATA-1:0]  dout_im,
  output logic                               frame_start,
  output logic                               frame_err
);

  localparam logic [LOG_N-1:0]    WR_MAX = LOG_N'(N - 1);
  localparam logic [LOG_VECS-1:0] RD_MAX = LOG_VECS'(VECS - 1);

  logic [LOG_N-1:0]    wr_cnt;
  logic                wb;
  logic                rb;
  logic [1:0]          bank_full;
  logic [LOG_VECS-1:0] rd_cnt;
  rd_state_t           state;
  rd_state_t           state_nxt;

  logic                accept;
  logic                wr_end;
  logic                frame_done;
  logic                err_set;
  logic [1:0]          full_set;
  logic [1:0]          full_clr;
  logic                rd_en;
  logic                rd_end;
  cplx_t               wr_sample;
  cplx_t [ARRAY-1:0]   rd_vec;

  // ---------------- write side ----------------
  assign s_ready    = !bank_full[wb];
  assign accept     = s_valid && s_ready;
  assign wr_end     = (wr_cnt == WR_MAX);
  assign frame_done = accept && wr_end;
  // Early s_last drops the partial frame; a missing s_last still completes it.
  assign err_set    = accept && (s_last != wr_end);
  assign wr_sample  = cplx_t'{re: s_re, im: s_im};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt <= '0;
      wb     <= 1'b0;
    end else if (accept) begin
      if (wr_end || s_last) wr_cnt <= '0;
      else                  wr_cnt <= wr_cnt + 1'b1;
      if (wr_end) wb <= ~wb;
    end
  end

  // Writer sets bank wb, reader clears bank rb; they are never the same bank
  // when both fire, since the writer only targets a non-full bank.
  assign full_set = frame_done ? (2'b01 << wb) : 2'b00;
  assign full_clr = rd_end     ? (2'b01 << rb) : 2'b00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bank_full <= 2'b00;
    else       bank_full <= (bank_full | full_set) & ~full_clr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        frame_err <= 1'b0;
    else if (err_set) frame_err <= 1'b1;
    else if (err_clr) frame_err <= 1'b0;
  end

  // ---------------- storage ----------------
  fft_frame_bank u_bank (
    .clk     (clk),
    .we      (accept),
    .wr_bank (wb),
    .wr_vec  (wr_cnt[LOG_N-1:LOG_ARRAY]),
    .wr_lane (wr_cnt[LOG_ARRAY-1:0]),
    .wr_data (wr_sample),
    .rd_bank (rb),
    .rd_vec  (rd_cnt),
    .rd_data (rd_vec)
  );

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bank_full[rb]) state_nxt = STREAM;
      // Chain straight into the other bank when it is already full so
      // consecutive frames stream with no gap.
      STREAM:  if (rd_end && !bank_full[~rb]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en  = (state == STREAM);
    rd_end = rd_en && (rd_cnt == RD_MAX);
  end

  // rd_cnt wraps to 0 on its own after the last vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= '0;
      rb     <= 1'b0;
    end else begin
      if (rd_en) rd_cnt <= rd_cnt + 1'b1;
      else       rd_cnt <= '0;
      if (rd_end) rb <= ~rb;
    end
  end

  // Output registers; dout holds its last vector while valid_out is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
      dout_re     <= '0;
      dout_im     <= '0;
    end else if (rd_en) begin
      valid_out   <= 1'b1;
      frame_start <= (rd_cnt == '0);
      for (int l = 0; l < ARRAY; l++) begin
        dout_re[l] <= rd_vec[l].re;
        dout_im[l] <= rd_vec[l].im;
      end
    end else begin
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: self-checking bench for fft_input_framer.
// Expected output vectors are built from the driven samples and queued when
// a frame completes; the monitor pops and compares one per valid_out cycle.
module tb_fft_input_framer;
  import fft_pkg::*;

  localparam int W = 1 + 2 * ARRAY * DATA;

  // ---------------- clock / reset / DUT ----------------
  logic                              clk = 1'b0;
  logic                              rstn;
  logic                              s_valid;
  logic                              s_ready;
  logic signed [DATA-1:0]            s_re;
  logic signed [DATA-1:0]            s_im;
  logic                              s_last;
  logic                              err_clr;
  logic                              valid_out;
  logic signed [ARRAY-1:0][DATA-1:0] dout_re;
  logic signed [ARRAY-1:0][DATA-1:0] dout_im;
  logic                              frame_start;
  logic                              frame_err;

  always #5 clk = ~clk;

  fft_input_framer dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_re        (s_re),
    .s_im        (s_im),
    .s_last      (s_last),
    .err_clr     (err_clr),
    .valid_out   (valid_out),
    .dout_re     (dout_re),
    .dout_im     (dout_im),
    .frame_start (frame_start),
    .frame_err   (frame_err)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]    exp_q[$];
  logic [DATA-1:0] fr_re [N];
  logic [DATA-1:0] fr_im [N];
  int              mcnt      = 0;
  bit              exp_err   = 1'b0;
  int              errors    = 0;
  int              checks    = 0;
  int              stall_cnt = 0;
  int              run_len   = 0;
  int              vec_seen  = 0;

  task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model of the write side: store the sample, push a frame's vectors on completion.
  task automatic model_accept(input int re, input int im, input bit last, input bit clr);
    bit e;
    logic [ARRAY-1:0][DATA-1:0] vr;
    logic [ARRAY-1:0][DATA-1:0] vi;
    bit fs;
    e = 1'b0;
    fr_re[mcnt] = re[DATA-1:0];
    fr_im[mcnt] = im[DATA-1:0];
    if (mcnt == N - 1) begin
      for (int v = 0; v < VECS; v++) begin
        for (int l = 0; l < ARRAY; l++) begin
          vr[l] = fr_re[v * ARRAY + l];
          vi[l] = fr_im[v * ARRAY + l];
        end
        fs = (v == 0);
        exp_q.push_back({fs, vr, vi});
      end
      if (!last) e = 1'b1;
      mcnt = 0;
    end else if (last) begin
      e = 1'b1;
      mcnt = 0;
    end else begin
      mcnt++;
    end
    if (e)        exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input int re, input int im, input bit last, input bit clr);
    int  waits;
    bit  rdy;
    waits   = 0;
    s_valid = 1'b1;
    s_re    = re[DATA-1:0];
    s_im    = im[DATA-1:0];
    s_last  = last;
    err_clr = clr;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      if (!rdy) waits++;
    end while (!rdy && waits < 1000);
    #1;
    stall_cnt += waits;
    err_clr = 1'b0;
    if (!rdy) check_val("accept_timeout", 0, 1);
    else      model_accept(re, im, last, clr);
  endtask

  task automatic idle_cycles(input int k);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rand_frame(input int len, input bit last_at_end, input int max_gap);
    for (int n = 0; n < len; n++) begin
      if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
      send($urandom_range(0, 1023), $urandom_range(0, 1023), last_at_end && (n == len - 1), 1'b0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_out) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_timeout", (n < 500), 1);
    idle_cycles(2);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (!rstn) begin
      run_len = 0;
    end else if (valid_out) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_vec", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check_val("vec", {frame_start, dout_re, dout_im}, exp);
      end
      run_len++;
      vec_seen++;
    end else if (run_len != 0) begin
      check_val("burst_len", run_len % VECS, 0);
      run_len = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_re    = '0;
    s_im    = '0;
    s_last  = 1'b0;
    err_clr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", valid_out, 0);
    check_val("rst_fstart", frame_start, 0);
    check_val("rst_err", frame_err, 0);
    check_val("rst_dout_re", dout_re, 0);
    check_val("rst_dout_im", dout_im, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_val("rst_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // Ramp frame with latency check.
    for (int i = 0; i < N; i++) send(i, -i, (i == N - 1), 1'b0);
    idle_cycles(0);
    check_val("lat_e0", valid_out, 0);
    @(posedge clk); #1;
    check_val("lat_e1", valid_out, 0);
    @(posedge clk); #1;
    check_val("lat_e2_valid", valid_out, 1);
    check_val("lat_e2_fstart", frame_start, 1);
    wait_drain();
    check_val("ramp_err", frame_err, 0);

    // Three back-to-back frames with s_valid held high.
    stall_cnt = 0;
    for (int f = 0; f < 3; f++) send_rand_frame(N, 1'b1, 0);
    idle_cycles(0);
    check_val("b2b_stalls", stall_cnt, 0);
    wait_drain();

    // Two frames with random source gaps.
    for (int f = 0; f < 2; f++) send_rand_frame(N, 1'b1, 2);
    idle_cycles(0);
    wait_drain();
    check_val("gap_err", frame_err, exp_err);

    // Early s_last at n=100: frame dropped, error set.
    send_rand_frame(101, 1'b1, 0);
    idle_cycles(3);
    check_val("early_err", frame_err, exp_err);
    send_rand_frame(N, 1'b1, 0);
    idle_cycles(0);
    wait_drain();
    check_val("err_sticky", frame_err, exp_err);
    pulse_clr();
    check_val("err_clr", frame_err, exp_err);

    // err_clr coinciding with a new early-last error: set wins.
    for (int i = 0; i < 50; i++) send($urandom_range(0, 1023), $urandom_range(0, 1023), (i == 49), (i == 49));
    idle_cycles(1);
    check_val("err_set_wins", frame_err, exp_err);
    pulse_clr();
    check_val("err_clr2", frame_err, exp_err);

    // Missing s_last on sample N-1: frame still streamed, error set.
    send_rand_frame(N, 1'b0, 0);
    idle_cycles(0);
    wait_drain();
    check_val("missing_last_err", frame_err, exp_err);

    // Async reset in the middle of a burst.
    send_rand_frame(N, 1'b1, 0);
    idle_cycles(0);
    base = vec_seen;
    n = 0;
    while (vec_seen < base + 10 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("mid_burst_reach", (n < 200), 1);
    #1 rstn = 1'b0;
    #1;
    check_val("mid_rst_valid", valid_out, 0);
    check_val("mid_rst_fstart", frame_start, 0);
    check_val("mid_rst_dout_re", dout_re, 0);
    check_val("mid_rst_dout_im", dout_im, 0);
    check_val("mid_rst_err", frame_err, 0);
    exp_q.delete();
    mcnt    = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", s_ready, 1);
    @(posedge clk);
    #1;
    send_rand_frame(N, 1'b1, 0);
    idle_cycles(0);
    wait_drain();
    check_val("post_rst_err", frame_err, exp_err);
    check_val("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
